// File: rtl/masked_and_dom.sv
// Domain-oriented masked AND gadget: D Boolean shares per operand, one
// register stage of refreshed cross products, then a per-share XOR compression.
module masked_and_dom #(
    parameter int D = 2,
    localparam int RAND_SIZE = D * (D - 1) / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  logic [D-1:0]         ina,
    input  logic [D-1:0]         inb,
    input  logic [RAND_SIZE-1:0] rin,
    output logic [D-1:0]         out,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_COMP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [D*D-1:0]   r_prod;
    logic [D*D-1:0]   w_prod_next;
    logic [D-1:0]     r_out;
    logic [D-1:0]     w_comp;
    logic             r_done;
    logic             w_load_prod;
    logic             w_load_out;

    // Each product term touches exactly one share of a and one share of b;
    // the random bit shared by the mirrored pair (i,j)/(j,i) hides the cross term.
    for (genvar gi = 0; gi < D; gi++) begin : g_row
        for (genvar gj = 0; gj < D; gj++) begin : g_col
            if (gi == gj) begin : g_diag
                assign w_prod_next[gi*D+gj] = ina[gi] & inb[gj];
            end else begin : g_cross
                localparam int LO = (gi < gj) ? gi : gj;
                localparam int HI = (gi < gj) ? gj : gi;
                localparam int K  = LO * D - LO * (LO + 1) / 2 + (HI - LO - 1);
                assign w_prod_next[gi*D+gj] = (ina[gi] & inb[gj]) ^ rin[K];
            end
        end
        // Compression reads only the registered row of share gi.
        assign w_comp[gi] = ^r_prod[gi*D +: D];
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        w_load_prod  = 1'b0;
        w_load_out   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_MULT;
                    w_load_prod  = 1'b1;
                end
            end
            S_MULT: w_state_next = S_COMP;
            S_COMP: begin
                w_state_next = S_IDLE;
                w_load_out   = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prod  <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_load_out;
            if (w_load_prod) begin
                r_prod <= w_prod_next;
            end
            if (w_load_out) begin
                r_out <= w_comp;
            end
        end
    end

    assign out  = r_out;
    assign done = r_done;

endmodule

// File: tb/tb_masked_and_dom.sv
// Directed bench for masked_and_dom with a D=2 and a D=3 instance side by side.
module tb_masked_and_dom;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start2 = 1'b0;
    logic [1:0] ina2 = '0;
    logic [1:0] inb2 = '0;
    logic [0:0] rin2 = '0;
    logic [1:0] out2;
    logic       done2;
    logic       ready2;

    logic       start3 = 1'b0;
    logic [2:0] ina3 = '0;
    logic [2:0] inb3 = '0;
    logic [2:0] rin3 = '0;
    logic [2:0] out3;
    logic       done3;
    logic       ready3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    masked_and_dom #(.D(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .ready(ready2),
        .ina(ina2), .inb(inb2), .rin(rin2), .out(out2), .done(done2)
    );

    masked_and_dom #(.D(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .ready(ready3),
        .ina(ina3), .inb(inb3), .rin(rin3), .out(out3), .done(done3)
    );

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] r;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One operation on the selected instance: ready at request, done exactly
    // two cycles after the accepting edge, and only for one cycle.
    task automatic run_op(input bit d3, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] r, input string name, output logic [2:0] o);
        @(negedge clk);
        if (d3) begin
            ina3 = a; inb3 = b; rin3 = r; start3 = 1'b1;
            check({name, "_ready"}, 32'(ready3), 32'd1);
        end else begin
            ina2 = a[1:0]; inb2 = b[1:0]; rin2 = r[0:0]; start2 = 1'b1;
            check({name, "_ready"}, 32'(ready2), 32'd1);
        end
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
        for (int n = 0; n < 2; n++) begin
            check({name, "_early"}, 32'(d3 ? done3 : done2), 32'd0);
            @(negedge clk);
        end
        check({name, "_done"}, 32'(d3 ? done3 : done2), 32'd1);
        o = d3 ? out3 : {1'b0, out2};
        @(negedge clk);
        check({name, "_pulse"}, 32'(d3 ? done3 : done2), 32'd0);
    endtask

    initial begin
        logic [2:0] o;
        int         n_done;

        tbl[0] = '{a: 3'b111, b: 3'b001, r: 3'b000, exp: 3'b111, name: "v3_a111_b001_r000"};
        tbl[1] = '{a: 3'b111, b: 3'b001, r: 3'b111, exp: 3'b111, name: "v3_a111_b001_r111"};
        tbl[2] = '{a: 3'b000, b: 3'b111, r: 3'b101, exp: 3'b101, name: "v3_a000_b111_r101"};
        tbl[3] = '{a: 3'b010, b: 3'b100, r: 3'b011, exp: 3'b100, name: "v3_a010_b100_r011"};
        tbl[4] = '{a: 3'b101, b: 3'b011, r: 3'b010, exp: 3'b101, name: "v3_a101_b011_r010"};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out2", 32'(out2), 32'd0);
        check("rst_done2", 32'(done2), 32'd0);
        check("rst_ready2", 32'(ready2), 32'd1);
        check("rst_out3", 32'(out3), 32'd0);
        check("rst_done3", 32'(done3), 32'd0);
        check("rst_ready3", 32'(ready3), 32'd1);

        // D=2 basic: a=01 (XOR 1), b=11 (XOR 0), rin=1 -> shares 11
        run_op(1'b0, 3'b001, 3'b011, 3'b001, "d2_basic", o);
        check("d2_basic_out", 32'(o), 32'b11);
        $display("d2 ina=01 inb=11 rin=1 -> out=%b", o[1:0]);

        // D=3 table
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].name, o);
            check({tbl[i].name, "_out"}, 32'(o), 32'(tbl[i].exp));
            $display("%s -> out=%b", tbl[i].name, o);
        end

        // D=3 exhaustive: recombined output must equal the unmasked AND
        for (int v = 0; v < 512; v++) begin
            logic [2:0] a, b, r;
            a = v[8:6]; b = v[5:3]; r = v[2:0];
            run_op(1'b1, a, b, r, "ex", o);
            check($sformatf("ex_a%b_b%b_r%b", a, b, r), 32'(^o), 32'((^a) & (^b)));
        end
        $display("exhaustive D=3 sweep of 512 cases checked");

        // start held high 9 cycles on D=3: accepts at edges 0,3,6
        @(negedge clk);
        ina3 = 3'b101; inb3 = 3'b011; rin3 = 3'b010; start3 = 1'b1;
        n_done = 0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("hold_ready_k%0d", k), 32'(ready3), 32'((k % 3) == 2));
            check($sformatf("hold_done_k%0d", k), 32'(done3), 32'((k % 3) == 2));
            if (done3) begin
                n_done++;
                check($sformatf("hold_out_k%0d", k), 32'(out3), 32'b101);
            end
        end
        start3 = 1'b0;
        check("hold_ndone", 32'(n_done), 32'd3);
        $display("start held 9 cycles -> %0d done pulses", n_done);

        // D=2 operation that leaves out=01, so the following test sees a change
        run_op(1'b0, 3'b001, 3'b001, 3'b000, "d2_prep", o);
        check("d2_prep_out", 32'(o), 32'b01);

        // Inputs changed during MULT must not affect the result
        @(negedge clk);
        ina2 = 2'b01; inb2 = 2'b11; rin2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; ina2 = 2'b10; inb2 = 2'b10; rin2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midchg_done", 32'(done2), 32'd1);
        check("midchg_out", 32'(out2), 32'b11);
        $display("d2 inputs changed in MULT -> out=%b", out2);

        // rst with start in the same cycle: start is dropped
        @(negedge clk);
        rst = 1'b1; start2 = 1'b1; ina2 = 2'b01; inb2 = 2'b01; rin2 = 1'b0;
        @(negedge clk);
        rst = 1'b0; start2 = 1'b0;
        check("rststart_ready", 32'(ready2), 32'd1);
        check("rststart_out", 32'(out2), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rststart_nodone_k%0d", k), 32'(done2), 32'd0);
        end
        $display("rst with start -> start dropped, ready=%b", ready2);

        // Make out nonzero again, then abort an operation in COMP
        run_op(1'b0, 3'b001, 3'b011, 3'b001, "d2_pre_abort", o);
        check("d2_pre_abort_out", 32'(o), 32'b11);
        @(negedge clk);
        ina2 = 2'b01; inb2 = 2'b01; rin2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_done", 32'(done2), 32'd0);
        check("abort_out", 32'(out2), 32'd0);
        check("abort_ready", 32'(ready2), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_nodone_k%0d", k), 32'(done2), 32'd0);
        end
        $display("rst in COMP -> done=%b out=%b", done2, out2);
        run_op(1'b0, 3'b001, 3'b001, 3'b000, "d2_after_abort", o);
        check("d2_after_abort_out", 32'(o), 32'b01);
        $display("fresh op after abort -> out=%b", o[1:0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
